// File: rtl/uart_pkg.sv
// Shared UART definitions: FCR field positions, trigger encodings, fetch FSM states.
package uart_pkg;

   localparam int unsigned FCR_FIFO_EN = 0;
   localparam int unsigned FCR_RX_CLR  = 1;
   localparam int unsigned FCR_TRIG_LO = 6;
   localparam int unsigned FCR_TRIG_HI = 7;

   localparam logic [1:0] TRIG_1    = 2'd0;
   localparam logic [1:0] TRIG_QTR  = 2'd1;
   localparam logic [1:0] TRIG_HALF = 2'd2;
   localparam logic [1:0] TRIG_NEAR = 2'd3;

   typedef enum logic {
      RX_IDLE = 1'b0,
      RX_CAPT = 1'b1
   } rx_fetch_e;

   // The per-character error flag sits just above the character bits.
   function automatic int unsigned err_bit(input int unsigned width);
      return width;
   endfunction

   // Receive trigger level for a given selector and FIFO depth.
   function automatic int unsigned trig_level(input logic [1:0] sel, input int unsigned depth);
      int unsigned lvl;
      case (sel)
         TRIG_1:    lvl = 1;
         TRIG_QTR:  lvl = depth / 4;
         TRIG_HALF: lvl = depth / 2;
         TRIG_NEAR: lvl = depth - 2;
         default:   lvl = 1;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// Character-timeout timer: counts enabled clocks up to 4*char_time, then holds a sticky flag.
module uart_rx_timeout #(
   parameter int unsigned TO_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enable,
   input  logic            restart,
   input  logic [TO_W-1:0] char_time,
   output logic            expired
);

   localparam int unsigned CNT_W = TO_W + 2;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] limit;

   assign limit   = {char_time, 2'b00};
   assign cnt_inc = cnt + CNT_W'(1);

   // Count while enabled; restart clears both the count and the flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         expired <= 1'b0;
      end else if (restart) begin
         cnt     <= '0;
         expired <= 1'b0;
      end else if (!enable) begin
         cnt     <= '0;
      end else if (!expired) begin
         cnt <= cnt_inc;
         if (cnt_inc == limit) begin
            expired <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// 16550 receive controller: FIFO write/prefetch, occupancy, LSR status and RX interrupts.
module uart_rx_fifo_ctrl #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned TO_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fcr_wr,
   input  logic [7:0]       fcr_data,
   input  logic             rbr_rd,
   input  logic             lsr_rd,
   input  logic             rx_valid,
   input  logic [WIDTH:0]   rx_data,
   input  logic [TO_W-1:0]  char_time,
   output logic             fifo_write,
   output logic [WIDTH:0]   fifo_wdata,
   output logic             fifo_read,
   output logic             fifo_rst_n,
   input  logic [WIDTH:0]   fifo_rdata,
   input  logic             fifo_empty,
   input  logic             fifo_full,
   output logic [WIDTH-1:0] rbr_data,
   output logic             rbr_valid,
   output logic             overrun,
   output logic             rx_err,
   output logic             int_rda,
   output logic             int_timeout
);

   import uart_pkg::*;

   localparam int unsigned OCC_W = $clog2(DEPTH + 1) + 1;
   localparam int unsigned ERR_B = err_bit(WIDTH);

   logic             fifo_en;
   logic [1:0]       trig_sel;
   logic [OCC_W-1:0] occ;
   logic [OCC_W-1:0] err_cnt;
   logic [OCC_W-1:0] level;
   logic             rbr_err;
   logic             clr_req;
   logic             in_clr;
   logic             wr_ok;
   logic             rd_acc;
   logic             ovr_evt;
   logic             can_fetch;
   logic             err_inc;
   logic             err_dec;
   logic             to_enable;
   logic             to_restart;
   logic             unused_fcr;
   rx_fetch_e        state;
   rx_fetch_e        state_nxt;

   assign unused_fcr = ^fcr_data[5:2];

   // A clear is requested by RX_CLR or by toggling the FIFO enable.
   assign clr_req   = fcr_wr & (fcr_data[FCR_RX_CLR] | (fcr_data[FCR_FIFO_EN] != fifo_en));
   assign in_clr    = ~fifo_rst_n;
   assign wr_ok     = fifo_en ? ~fifo_full : (occ == '0);
   assign fifo_write = rx_valid & wr_ok & ~in_clr;
   assign fifo_wdata = rx_data;
   assign ovr_evt   = rx_valid & ~wr_ok & ~in_clr;
   assign rd_acc    = rbr_rd & rbr_valid;
   assign can_fetch = ~rbr_valid & ~fifo_empty & ~in_clr;
   assign err_inc   = fifo_write & rx_data[ERR_B];
   assign err_dec   = rd_acc & rbr_err;
   assign rx_err    = (err_cnt != '0);
   assign level     = OCC_W'(trig_level(fifo_en ? trig_sel : TRIG_1, DEPTH));

   // FCR shadow registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_en  <= 1'b0;
         trig_sel <= TRIG_1;
      end else if (fcr_wr) begin
         fifo_en  <= fcr_data[FCR_FIFO_EN];
         trig_sel <= fcr_data[FCR_TRIG_HI:FCR_TRIG_LO];
      end
   end

   // One-cycle synchronous FIFO clear pulse following the FCR write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_rst_n <= 1'b1;
      end else begin
         fifo_rst_n <= ~clr_req;
      end
   end

   // Occupancy (FIFO plus holding register) and flagged-character count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ     <= '0;
         err_cnt <= '0;
      end else if (clr_req) begin
         occ     <= '0;
         err_cnt <= '0;
      end else begin
         if (fifo_write && !rd_acc) begin
            occ <= occ + OCC_W'(1);
         end else if (!fifo_write && rd_acc) begin
            occ <= occ - OCC_W'(1);
         end
         if (err_inc && !err_dec) begin
            err_cnt <= err_cnt + OCC_W'(1);
         end else if (!err_inc && err_dec) begin
            err_cnt <= err_cnt - OCC_W'(1);
         end
      end
   end

   // Prefetch FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RX_IDLE;
      end else if (clr_req) begin
         state <= RX_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Prefetch FSM next state: fetch when the holding register is free.
   always_comb begin
      state_nxt = state;
      case (state)
         RX_IDLE: if (can_fetch) state_nxt = RX_CAPT;
         RX_CAPT: state_nxt = RX_IDLE;
         default: state_nxt = RX_IDLE;
      endcase
   end

   // Prefetch FSM output: FIFO read strobe.
   always_comb begin
      fifo_read = 1'b0;
      if (state == RX_IDLE) begin
         fifo_read = can_fetch;
      end
   end

   // Receive-buffer holding register, loaded from the FIFO output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rbr_valid <= 1'b0;
         rbr_data  <= '0;
         rbr_err   <= 1'b0;
      end else if (clr_req) begin
         rbr_valid <= 1'b0;
         rbr_err   <= 1'b0;
      end else if (state == RX_CAPT) begin
         rbr_valid <= 1'b1;
         rbr_data  <= fifo_rdata[WIDTH-1:0];
         rbr_err   <= fifo_rdata[ERR_B];
      end else if (rd_acc) begin
         rbr_valid <= 1'b0;
      end
   end

   // Sticky overrun; a new overrun beats a simultaneous LSR read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun <= 1'b0;
      end else if (ovr_evt) begin
         overrun <= 1'b1;
      end else if (lsr_rd) begin
         overrun <= 1'b0;
      end
   end

   // Received-data-available interrupt from occupancy vs trigger level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         int_rda <= 1'b0;
      end else begin
         int_rda <= (occ >= level);
      end
   end

   assign to_enable  = fifo_en & (char_time != '0) & (occ != '0);
   assign to_restart = fifo_write | rd_acc | clr_req;

   uart_rx_timeout #(
      .TO_W (TO_W)
   ) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .enable    (to_enable),
      .restart   (to_restart),
      .char_time (char_time),
      .expired   (int_timeout)
   );

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Self-checking bench for uart_rx_fifo_ctrl with a behavioural 16-deep RX FIFO.
module tb_uart_rx_fifo_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        fcr_wr;
   logic [7:0]  fcr_data;
   logic        rbr_rd;
   logic        lsr_rd;
   logic        rx_valid;
   logic [8:0]  rx_data;
   logic [15:0] char_time;
   logic        fifo_write;
   logic [8:0]  fifo_wdata;
   logic        fifo_read;
   logic        fifo_rst_n;
   logic [8:0]  fifo_rdata;
   logic        fifo_empty;
   logic        fifo_full;
   logic [7:0]  rbr_data;
   logic        rbr_valid;
   logic        overrun;
   logic        rx_err;
   logic        int_rda;
   logic        int_timeout;

   int n_chk  = 0;
   int n_fail = 0;

   uart_rx_fifo_ctrl #(.DEPTH(16), .WIDTH(8), .TO_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .fcr_wr      (fcr_wr),
      .fcr_data    (fcr_data),
      .rbr_rd      (rbr_rd),
      .lsr_rd      (lsr_rd),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .char_time   (char_time),
      .fifo_write  (fifo_write),
      .fifo_wdata  (fifo_wdata),
      .fifo_read   (fifo_read),
      .fifo_rst_n  (fifo_rst_n),
      .fifo_rdata  (fifo_rdata),
      .fifo_empty  (fifo_empty),
      .fifo_full   (fifo_full),
      .rbr_data    (rbr_data),
      .rbr_valid   (rbr_valid),
      .overrun     (overrun),
      .rx_err      (rx_err),
      .int_rda     (int_rda),
      .int_timeout (int_timeout)
   );

   always #5 clk = ~clk;

   // Behavioural synchronous FIFO with registered output and sync clear.
   logic [8:0] f_mem [16];
   logic [3:0] f_wp, f_rp;
   int         f_cnt;
   assign fifo_empty = (f_cnt == 0);
   assign fifo_full  = (f_cnt == 16);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         f_wp <= '0; f_rp <= '0; f_cnt <= 0; fifo_rdata <= '0;
      end else if (!fifo_rst_n) begin
         f_wp <= '0; f_rp <= '0; f_cnt <= 0;
      end else begin
         if (fifo_read && f_cnt != 0) begin
            fifo_rdata <= f_mem[f_rp];
            f_rp <= f_rp + 4'd1;
         end
         if (fifo_write && f_cnt != 16) begin
            f_mem[f_wp] <= fifo_wdata;
            f_wp <= f_wp + 4'd1;
         end
         f_cnt <= f_cnt + ((fifo_write && f_cnt != 16) ? 1 : 0) - ((fifo_read && f_cnt != 0) ? 1 : 0);
      end
   end

   typedef struct {
      logic       rxv;
      logic [8:0] rxd;
      logic       rd;
      logic       ev;
      logic [7:0] ed;
      logic       erda;
      logic       eerr;
   } vec_t;

   localparam int NV = 13;
   vec_t va [NV];

   function automatic vec_t mk(input logic rxv, input logic [8:0] rxd, input logic rd,
                               input logic ev, input logic [7:0] ed, input logic erda,
                               input logic eerr);
      vec_t v;
      v.rxv = rxv; v.rxd = rxd; v.rd = rd; v.ev = ev; v.ed = ed; v.erda = erda; v.eerr = eerr;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic write_fcr(input logic [7:0] d);
      fcr_wr = 1'b1; fcr_data = d;
      tick();
      fcr_wr = 1'b0; fcr_data = 8'h00;
   endtask

   task automatic read_one(input logic [7:0] exp);
      int n;
      n = 0;
      while (!rbr_valid && n < 10) begin
         tick();
         n++;
      end
      chk("read_valid", 32'(rbr_valid), 32'd1);
      chk("read_data", 32'(rbr_data), 32'(exp));
      rbr_rd = 1'b1;
      tick();
      rbr_rd = 1'b0;
   endtask

   initial begin
      rst = 1'b1; fcr_wr = 1'b0; fcr_data = 8'h00; rbr_rd = 1'b0; lsr_rd = 1'b0;
      rx_valid = 1'b0; rx_data = '0; char_time = 16'd0;

      // Directed per-cycle vectors: basic fetch, flagged char, back-to-back reads.
      va[0]  = mk(1'b1, 9'h041, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      va[1]  = mk(1'b0, 9'h000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      va[2]  = mk(1'b0, 9'h000, 1'b0, 1'b1, 8'h41, 1'b1, 1'b0);
      va[3]  = mk(1'b0, 9'h000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      va[4]  = mk(1'b0, 9'h000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      va[5]  = mk(1'b1, 9'h1FF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      va[6]  = mk(1'b1, 9'h042, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      va[7]  = mk(1'b0, 9'h000, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
      va[8]  = mk(1'b0, 9'h000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      va[9]  = mk(1'b0, 9'h000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      va[10] = mk(1'b0, 9'h000, 1'b0, 1'b1, 8'h42, 1'b1, 1'b0);
      va[11] = mk(1'b0, 9'h000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      va[12] = mk(1'b0, 9'h000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_fifo_write", 32'(fifo_write), 32'd0);
      chk("rst_fifo_read", 32'(fifo_read), 32'd0);
      chk("rst_fifo_rst_n", 32'(fifo_rst_n), 32'd1);
      chk("rst_rbr_valid", 32'(rbr_valid), 32'd0);
      chk("rst_rbr_data", 32'(rbr_data), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_rx_err", 32'(rx_err), 32'd0);
      chk("rst_int_rda", 32'(int_rda), 32'd0);
      chk("rst_int_timeout", 32'(int_timeout), 32'd0);

      // Enabling the FIFO is itself a clear.
      write_fcr(8'h01);
      chk("en_clr_low", 32'(fifo_rst_n), 32'd0);
      tick();
      chk("en_clr_high", 32'(fifo_rst_n), 32'd1);

      for (int i = 0; i < NV; i++) begin
         rx_valid = va[i].rxv; rx_data = va[i].rxd; rbr_rd = va[i].rd;
         tick();
         chk($sformatf("vec%0d_rbr_valid", i), 32'(rbr_valid), 32'(va[i].ev));
         if (va[i].ev) chk($sformatf("vec%0d_rbr_data", i), 32'(rbr_data), 32'(va[i].ed));
         chk($sformatf("vec%0d_int_rda", i), 32'(int_rda), 32'(va[i].erda));
         chk($sformatf("vec%0d_rx_err", i), 32'(rx_err), 32'(va[i].eerr));
      end
      rx_valid = 1'b0; rbr_rd = 1'b0;

      // Trigger level DEPTH/2 = 8.
      write_fcr(8'h81);
      chk("trig_no_clear", 32'(fifo_rst_n), 32'd1);
      for (int i = 0; i < 7; i++) begin
         rx_valid = 1'b1; rx_data = 9'(8'h30 + i);
         tick();
      end
      rx_valid = 1'b0;
      repeat (3) tick();
      chk("trig_occ7", 32'(int_rda), 32'd0);
      rx_valid = 1'b1; rx_data = 9'h037;
      tick();
      rx_valid = 1'b0;
      tick();
      chk("trig_occ8", 32'(int_rda), 32'd1);
      chk("trig_head", 32'(rbr_data), 32'h30);
      rbr_rd = 1'b1;
      tick();
      rbr_rd = 1'b0;
      tick();
      chk("trig_after_read", 32'(int_rda), 32'd0);
      for (int i = 1; i < 8; i++) read_one(8'(8'h30 + i));

      // Fill to 17 (16 in FIFO + holding) then overflow.
      for (int i = 0; i < 17; i++) begin
         rx_valid = 1'b1; rx_data = 9'(8'h10 + i);
         tick();
      end
      rx_valid = 1'b0;
      repeat (3) tick();
      chk("full_int_rda", 32'(int_rda), 32'd1);
      chk("full_no_ovr", 32'(overrun), 32'd0);
      rx_valid = 1'b1; rx_data = 9'h0EE;
      #1;
      chk("full_write_blocked", 32'(fifo_write), 32'd0);
      tick();
      rx_valid = 1'b0;
      chk("ovr_set", 32'(overrun), 32'd1);
      rx_valid = 1'b1; lsr_rd = 1'b1;
      tick();
      rx_valid = 1'b0; lsr_rd = 1'b0;
      chk("ovr_set_wins", 32'(overrun), 32'd1);
      lsr_rd = 1'b1;
      tick();
      lsr_rd = 1'b0;
      chk("ovr_lsr_clear", 32'(overrun), 32'd0);
      for (int i = 0; i < 17; i++) read_one(8'(8'h10 + i));
      repeat (3) tick();
      chk("full_drained", 32'(rbr_valid), 32'd0);

      // Character timeout: 4 * 10 clocks after the last write.
      char_time = 16'd10;
      write_fcr(8'h01);
      tick();
      rx_valid = 1'b1; rx_data = 9'h099;
      tick();
      rx_valid = 1'b0;
      chk("to_fetch_read", 32'(fifo_read), 32'd1);
      repeat (39) tick();
      chk("to_before", 32'(int_timeout), 32'd0);
      tick();
      chk("to_at_40", 32'(int_timeout), 32'd1);
      rbr_rd = 1'b1;
      tick();
      rbr_rd = 1'b0;
      chk("to_cleared", 32'(int_timeout), 32'd0);

      // Non-FIFO mode: single-character capacity.
      write_fcr(8'h00);
      tick();
      rx_valid = 1'b1; rx_data = 9'h055;
      tick();
      rx_data = 9'h066;
      #1;
      chk("nf_second_blocked", 32'(fifo_write), 32'd0);
      tick();
      rx_valid = 1'b0;
      chk("nf_overrun", 32'(overrun), 32'd1);
      tick();
      chk("nf_valid", 32'(rbr_valid), 32'd1);
      chk("nf_data", 32'(rbr_data), 32'h55);
      repeat (45) tick();
      chk("nf_no_timeout", 32'(int_timeout), 32'd0);
      read_one(8'h55);
      repeat (3) tick();
      chk("nf_dropped", 32'(rbr_valid), 32'd0);

      // Error flag and FIFO clear; overrun survives the clear.
      write_fcr(8'h01);
      tick();
      chk("clr_ovr_kept_mode", 32'(overrun), 32'd1);
      rx_valid = 1'b1; rx_data = 9'h1FF;
      tick();
      rx_data = 9'h042;
      tick();
      rx_valid = 1'b0;
      repeat (4) tick();
      chk("err_set", 32'(rx_err), 32'd1);
      chk("err_head", 32'(rbr_data), 32'hFF);
      write_fcr(8'h03);
      chk("clr_low", 32'(fifo_rst_n), 32'd0);
      chk("clr_rx_err", 32'(rx_err), 32'd0);
      chk("clr_rbr_valid", 32'(rbr_valid), 32'd0);
      chk("clr_overrun_kept", 32'(overrun), 32'd1);
      rx_valid = 1'b1; rx_data = 9'h077;
      #1;
      chk("clr_write_forced", 32'(fifo_write), 32'd0);
      chk("clr_read_forced", 32'(fifo_read), 32'd0);
      tick();
      rx_valid = 1'b0;
      chk("clr_high", 32'(fifo_rst_n), 32'd1);
      lsr_rd = 1'b1;
      tick();
      lsr_rd = 1'b0;
      chk("clr_ovr_cleared", 32'(overrun), 32'd0);
      write_fcr(8'h03);
      rx_valid = 1'b1; rx_data = 9'h078;
      tick();
      rx_valid = 1'b0;
      chk("clr_drop_no_ovr", 32'(overrun), 32'd0);
      repeat (4) tick();
      chk("clr_empty", 32'(rbr_valid), 32'd0);

      // Reset while a fetch is in flight.
      rx_valid = 1'b1; rx_data = 9'h05A;
      tick();
      rx_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("midrst_read", 32'(fifo_read), 32'd0);
      chk("midrst_valid", 32'(rbr_valid), 32'd0);
      tick();
      rst = 1'b0;
      repeat (3) tick();
      chk("midrst_discard", 32'(rbr_valid), 32'd0);
      chk("midrst_int_rda", 32'(int_rda), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
